// File: rtl/int_ctrl_if.sv
// int_ctrl_if: CPU-side bus between a processor and int_ctrl.
//   Register access: reg_addr, reg_wdata, reg_we, reg_re -> reg_rdata
//   Interrupt handshake: int_req, int_vec -> int_ack
// Parameter NUM_SRC sizes the vector field (VW = $clog2(NUM_SRC)).
// master = CPU side, slave = controller side.
interface int_ctrl_if #(
  parameter int NUM_SRC = 8
);
  localparam int VW = $clog2(NUM_SRC);

  logic [1:0]    reg_addr;
  logic [15:0]   reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [15:0]   reg_rdata;
  logic          int_req;
  logic [VW-1:0] int_vec;
  logic          int_ack;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re, int_ack,
    input  reg_rdata, int_req, int_vec
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re, int_ack,
    output reg_rdata, int_req, int_vec
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller. Latches source pulses into PENDING, masks
// them with MASK, and presents the lowest-index enabled source to the CPU over
// a req/ack/EOI handshake. Optionally re-arms the int_timer one-shot.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   irq             interrupt source lines (level sampled each cycle)
//   bus             int_ctrl_if.slave: register bus + int_req/int_vec/int_ack
//   tmr_nxt_int     timer reload value
//   tmr_nxt_int_we  one-cycle timer load pulse
// Registers: 0 MASK (rw), 1 PENDING (r, w1c), 2 STATUS (r) / EOI (w),
//            3 RELOAD (rw when reload is built in).
// Build option: define INT_CTRL_TIMER_RELOAD_EN to enable timer re-arming;
// otherwise RELOAD reads 0 and the timer outputs are tied to 0.
//
// state   | meaning
// IDLE    | no request outstanding; pick next enabled pending source
// REQ     | int_req high, int_vec held, waiting for int_ack
// SERVICE | CPU is handling the interrupt, waiting for EOI
module int_ctrl #(
  parameter  int NUM_SRC   = 8,
  parameter  int TIMER_SRC = 0,
  localparam int VW        = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq,
  int_ctrl_if.slave          bus,
  output logic [15:0]        tmr_nxt_int,
  output logic               tmr_nxt_int_we
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] en_src;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [VW-1:0]      vec_q;
  logic [VW-1:0]      pick;
  logic               req_q;
  logic [15:0]        rdata_q;
  logic [15:0]        mask_ext;
  logic [15:0]        pend_ext;
  logic [15:0]        status_rd;
  logic [15:0]        reload_rd;
  logic [15:0]        rd_mux;
  logic               wr_mask;
  logic               wr_pend;
  logic               wr_eoi;
  logic               wr_reload;

  assign wr_mask   = bus.reg_we && (bus.reg_addr == 2'd0);
  assign wr_pend   = bus.reg_we && (bus.reg_addr == 2'd1);
  assign wr_eoi    = bus.reg_we && (bus.reg_addr == 2'd2);
  assign wr_reload = bus.reg_we && (bus.reg_addr == 2'd3);

  assign en_src = pend_q & mask_q;

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    pick = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (en_src[i]) pick = VW'(i);
    end
  end

  // A new irq in the same cycle as a clear (ack or W1C) keeps the bit set.
  always_comb begin
    ack_clr = '0;
    if (state_q == REQ && bus.int_ack) ack_clr[vec_q] = 1'b1;
    w1c      = wr_pend ? bus.reg_wdata[NUM_SRC-1:0] : '0;
    pend_nxt = (pend_q & ~(ack_clr | w1c)) | irq;
  end

  always_comb begin
    mask_ext                = '0;
    mask_ext[NUM_SRC-1:0]   = mask_q;
    pend_ext                = '0;
    pend_ext[NUM_SRC-1:0]   = pend_q;
    status_rd               = '0;
    status_rd[15]           = req_q;
    status_rd[14]           = (state_q == SERVICE);
    status_rd[VW-1:0]       = vec_q;
    unique case (bus.reg_addr)
      2'd0:    rd_mux = mask_ext;
      2'd1:    rd_mux = pend_ext;
      2'd2:    rd_mux = status_rd;
      default: rd_mux = reload_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      vec_q   <= '0;
      req_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      pend_q <= pend_nxt;
      if (wr_mask) mask_q <= bus.reg_wdata[NUM_SRC-1:0];
      // rd_mux reflects pre-write state, so a same-cycle write is not seen.
      if (bus.reg_re) rdata_q <= rd_mux;
      case (state_q)
        IDLE: begin
          if (|en_src) begin
            vec_q   <= pick;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          // MASK changes here do not withdraw the request.
          if (bus.int_ack) begin
            req_q   <= 1'b0;
            state_q <= SERVICE;
          end
        end
        SERVICE: begin
          if (wr_eoi) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.reg_rdata = rdata_q;
  assign bus.int_req   = req_q;
  assign bus.int_vec   = vec_q;

`ifdef INT_CTRL_TIMER_RELOAD_EN
  logic [15:0] reload_q;
  logic [15:0] tmr_nxt_q;
  logic        tmr_we_q;

  // A RELOAD write takes precedence over a same-cycle timer pulse, and
  // writing 0 both stops reloading and suppresses the pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reload_q  <= '0;
      tmr_nxt_q <= '0;
      tmr_we_q  <= 1'b0;
    end else begin
      tmr_we_q <= 1'b0;
      if (wr_reload) begin
        reload_q <= bus.reg_wdata;
        if (bus.reg_wdata != 16'd0) begin
          tmr_we_q  <= 1'b1;
          tmr_nxt_q <= bus.reg_wdata;
        end
      end else if (irq[TIMER_SRC] && reload_q != 16'd0) begin
        tmr_we_q  <= 1'b1;
        tmr_nxt_q <= reload_q;
      end
    end
  end

  assign reload_rd      = reload_q;
  assign tmr_nxt_int    = tmr_nxt_q;
  assign tmr_nxt_int_we = tmr_we_q;
`else
  logic unused_reload;

  assign reload_rd      = '0;
  assign tmr_nxt_int    = '0;
  assign tmr_nxt_int_we = 1'b0;
  assign unused_reload  = ^{wr_reload, irq[TIMER_SRC], bus.reg_wdata};
`endif

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

`ifdef INT_CTRL_TIMER_RELOAD_EN
  localparam bit RL = 1'b1;
`else
  localparam bit RL = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq;
  logic [15:0] tmr_nxt_int;
  logic        tmr_nxt_int_we;

  int total = 0;
  int bad   = 0;

  int_ctrl_if #(.NUM_SRC(8)) bus ();

  int_ctrl #(.NUM_SRC(8), .TIMER_SRC(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq            (irq),
    .bus            (bus),
    .tmr_nxt_int    (tmr_nxt_int),
    .tmr_nxt_int_we (tmr_nxt_int_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending set, mask, and whether a request is out or
  // being serviced, advanced one clock at a time from the register rules.
  logic [7:0]  m_pend, m_mask;
  logic [15:0] m_reload, m_rd, m_tnxt;
  bit          m_req, m_svc, m_twe;
  int          m_vec;

  function automatic int lowest(input logic [7:0] v);
    int r = -1;
    for (int b = 7; b >= 0; b--) if (v[b]) r = b;
    return r;
  endfunction

  task automatic model_step(input logic [7:0] i_irq, input logic [1:0] a,
                            input logic [15:0] d, input bit w, input bit r,
                            input bit k, input bit rs);
    logic [7:0] clr;
    int         nv;
    if (!rs) begin
      m_pend = 0; m_mask = 0; m_reload = 0; m_rd = 0; m_tnxt = 0;
      m_req = 0; m_svc = 0; m_twe = 0; m_vec = 0;
      return;
    end
    if (r) begin
      case (a)
        2'd0: m_rd = {8'h00, m_mask};
        2'd1: m_rd = {8'h00, m_pend};
        2'd2: m_rd = {m_req, m_svc, 11'd0, 3'(m_vec)};
        default: m_rd = RL ? m_reload : 16'h0000;
      endcase
    end
    m_twe = 0;
    if (RL) begin
      if (w && a == 2'd3) begin
        if (d != 0) begin m_twe = 1; m_tnxt = d; end
      end else if (i_irq[0] && m_reload != 0) begin
        m_twe = 1; m_tnxt = m_reload;
      end
      if (w && a == 2'd3) m_reload = d;
    end
    clr = 0;
    if (m_req && k) clr[m_vec] = 1'b1;
    if (w && a == 2'd1) clr = clr | d[7:0];
    if (!m_req && !m_svc) begin
      nv = lowest(m_pend & m_mask);
      if (nv >= 0) begin m_vec = nv; m_req = 1; end
    end else if (m_req) begin
      if (k) begin m_req = 0; m_svc = 1; end
    end else if (w && a == 2'd2) begin
      m_svc = 0;
    end
    m_pend = (m_pend & ~clr) | i_irq;
    if (w && a == 2'd0) m_mask = d[7:0];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc_r(input logic [7:0] i_irq, input logic [1:0] a,
                       input logic [15:0] d, input bit w, input bit r,
                       input bit k, input bit rs);
    irq = i_irq; bus.reg_addr = a; bus.reg_wdata = d;
    bus.reg_we = w; bus.reg_re = r; bus.int_ack = k; rst_n = rs;
    @(posedge clk);
    model_step(i_irq, a, d, w, r, k, rs);
    @(negedge clk);
    chk("model_req", bus.int_req, m_req);
    if (m_req) chk("model_vec", bus.int_vec, m_vec);
    chk("model_rdata", bus.reg_rdata, m_rd);
    chk("model_tmr_we", tmr_nxt_int_we, m_twe);
    if (m_twe) chk("model_tmr_nxt", tmr_nxt_int, m_tnxt);
  endtask

  task automatic cyc(input logic [7:0] i_irq, input logic [1:0] a,
                     input logic [15:0] d, input bit w, input bit r, input bit k);
    cyc_r(i_irq, a, d, w, r, k, 1'b1);
  endtask

  typedef struct {
    logic [7:0]  irq;
    logic [1:0]  a;
    logic [15:0] d;
    bit          w, r, k;
    bit          ereq;
    int          evec;
    bit          crd;
    logic [15:0] erd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] i, input logic [1:0] a,
                              input logic [15:0] d, input bit w, input bit r,
                              input bit k, input bit er, input int ev,
                              input bit cr, input logic [15:0] erd);
    vec_t v;
    v.irq = i; v.a = a; v.d = d; v.w = w; v.r = r; v.k = k;
    v.ereq = er; v.evec = ev; v.crd = cr; v.erd = erd;
    return v;
  endfunction

  initial begin
    logic [7:0]  ri;
    logic [1:0]  ra;
    logic [15:0] rd;
    bit          rw, rr, rk, rs;
    int          op;

    // irq, addr, wdata, we, re, ack | req, vec, check rdata, rdata
    tbl.push_back(mk(8'h00, 0, 16'h00FF, 1, 0, 0, 0, 0, 0, 16'h0000)); // MASK=FF
    tbl.push_back(mk(8'h24, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000)); // irq 5,2
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 0, 0, 1, 2, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 1, 16'h0000, 0, 1, 0, 1, 2, 1, 16'h0024));
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000)); // ack
    tbl.push_back(mk(8'h00, 2, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h4002));
    tbl.push_back(mk(8'h00, 2, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000)); // EOI
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 0, 0, 1, 5, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 2, 16'h0000, 0, 1, 0, 1, 5, 1, 16'h8005));
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 1, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h0000));
    tbl.push_back(mk(8'h00, 2, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000)); // MASK=0
    tbl.push_back(mk(8'h08, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 1, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h0008));
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 16'h0008, 1, 0, 0, 0, 0, 0, 16'h0000)); // MASK=08
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 0, 0, 1, 3, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 1, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h0000));
    tbl.push_back(mk(8'h08, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000)); // irq in SERVICE
    tbl.push_back(mk(8'h00, 2, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h4003));
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 2, 16'h1234, 1, 0, 0, 0, 0, 0, 16'h0000)); // EOI
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 0, 0, 1, 3, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 2, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(8'h10, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 1, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h0010));
    tbl.push_back(mk(8'h10, 1, 16'h0010, 1, 0, 0, 0, 0, 0, 16'h0000)); // W1C vs irq
    tbl.push_back(mk(8'h00, 1, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h0010));
    tbl.push_back(mk(8'h00, 1, 16'h0010, 1, 0, 0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 1, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 16'h00F0, 1, 1, 0, 0, 0, 1, 16'h0008)); // rd+wr
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h00F0));
    tbl.push_back(mk(8'h00, 0, 16'hFFFF, 1, 0, 0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h00FF));
    tbl.push_back(mk(8'h00, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000)); // ack in IDLE
    tbl.push_back(mk(8'h00, 2, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h0003));

    irq = 0; bus.reg_addr = 0; bus.reg_wdata = 0; bus.reg_we = 0;
    bus.reg_re = 0; bus.int_ack = 0; rst_n = 0;
    cyc_r(0, 0, 0, 0, 0, 0, 0);
    cyc_r(0, 0, 0, 0, 0, 0, 0);
    chk("rst_req", bus.int_req, 0);
    chk("rst_vec", bus.int_vec, 0);
    chk("rst_rdata", bus.reg_rdata, 0);
    chk("rst_tmr_we", tmr_nxt_int_we, 0);
    chk("rst_tmr_nxt", tmr_nxt_int, 0);

    foreach (tbl[n]) begin
      cyc(tbl[n].irq, tbl[n].a, tbl[n].d, tbl[n].w, tbl[n].r, tbl[n].k);
      chk($sformatf("tbl%0d_req", n), bus.int_req, tbl[n].ereq);
      if (tbl[n].ereq) chk($sformatf("tbl%0d_vec", n), bus.int_vec, tbl[n].evec);
      if (tbl[n].crd) chk($sformatf("tbl%0d_rdata", n), bus.reg_rdata, tbl[n].erd);
    end

    // Timer re-arm; with the option off the pulse must never appear.
    cyc(0, 0, 16'h0000, 1, 0, 0);
    cyc(0, 3, 16'h0003, 1, 0, 0);
    chk("rl_wr_we", tmr_nxt_int_we, RL);
    chk("rl_wr_nxt", tmr_nxt_int, RL ? 16'd3 : 16'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rl_pulse_end", tmr_nxt_int_we, 0);
    cyc(8'h01, 0, 0, 0, 0, 0);
    chk("rl_irq_we", tmr_nxt_int_we, RL);
    chk("rl_irq_nxt", tmr_nxt_int, RL ? 16'd3 : 16'd0);
    cyc(0, 3, 16'h0000, 1, 1, 0);
    chk("rl_zero_wr_we", tmr_nxt_int_we, 0);
    chk("rl_read_back", bus.reg_rdata, RL ? 16'd3 : 16'd0);
    cyc(8'h01, 0, 0, 0, 0, 0);
    chk("rl_stopped_we", tmr_nxt_int_we, 0);
    cyc(8'h01, 3, 16'h0005, 1, 0, 0);
    chk("rl_coll_we", tmr_nxt_int_we, RL);
    chk("rl_coll_nxt", tmr_nxt_int, RL ? 16'd5 : 16'd0);
    cyc(0, 1, 16'hFFFF, 1, 0, 0);
    chk("rl_single", tmr_nxt_int_we, 0);

    // Reset while a request is outstanding.
    cyc(0, 0, 16'h00FF, 1, 0, 0);
    cyc(8'h02, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pre_rst_req", bus.int_req, 1);
    chk("pre_rst_vec", bus.int_vec, 1);
    cyc_r(0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_req", bus.int_req, 0);
    chk("mid_rst_rdata", bus.reg_rdata, 0);
    for (int a = 0; a < 4; a++) begin
      cyc(0, 2'(a), 0, 0, 1, 0);
      chk($sformatf("post_rst_reg%0d", a), bus.reg_rdata, 0);
      chk("post_rst_req", bus.int_req, 0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      ri = 0;
      if ($urandom_range(0, 3) == 0) ri = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ri = ri | 8'($urandom);
      op = $urandom_range(0, 11);
      rw = 0; rd = 16'($urandom); ra = 2'($urandom_range(0, 3));
      case (op)
        0: begin rw = 1; ra = 0; end
        1: begin rw = 1; ra = 1; end
        2, 3: begin rw = 1; ra = 2; end
        4: begin rw = 1; ra = 3; rd = 16'($urandom_range(0, 2)); end
        default: rw = 0;
      endcase
      rr = ($urandom_range(0, 2) == 0);
      rk = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 599) != 0);
      cyc_r(ri, ra, rd, rw, rr, rk, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller for the interrupt sources, including the `int_timer` one-shot. It latches source pulses into a pending register, masks them, and picks the highest-priority enabled source. It presents one request with a vector to the CPU over a request/acknowledge/end-of-interrupt handshake. It also re-arms the timer for periodic ticks (see Configuration).

## Interface
Parameters:
- `NUM_SRC`, 8: number of interrupt sources, 2..16; index 0 is the highest priority.
- `TIMER_SRC`, 0: source index wired to the timer's `do_int`.
- `VW`, `$clog2(NUM_SRC)`: vector width (derived, not overridden).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `irq` in NUM_SRC: source lines; any cycle sampled high sets the pending bit.
- `reg_addr` in 2: register select.
- `reg_wdata` in 16: write data.
- `reg_we` in 1: register write strobe.
- `reg_re` in 1: register read strobe.
- `reg_rdata` out 16: registered read data.
- `int_req` out 1: interrupt request to the CPU.
- `int_vec` out VW: index of the requested source; stable while `int_req` is high.
- `int_ack` in 1: CPU accepts the request.
- `tmr_nxt_int` out 16: timer reload value, driven to `int_timer.nxt_int`.
- `tmr_nxt_int_we` out 1: timer load pulse, driven to `int_timer.nxt_int_we`.

## Operation
Registers:
- Addr 0, MASK: read/write. Bit i=1 enables source i. Bits ≥ NUM_SRC read 0.
- Addr 1, PENDING: read. Write-1-to-clear per bit.
- Addr 2, STATUS:
  - Read: bit15=`int_req`, bit14=in-service, bits[VW-1:0]=latched vector.
  - Write (any data): EOI.
- Addr 3, RELOAD: 16-bit timer reload value (see Configuration).

FSM states: IDLE, REQ, SERVICE.
- IDLE: if `PENDING & MASK` is nonzero, latch the lowest set index into `int_vec`, set `int_req`=1, and go to REQ.
- REQ: hold `int_req` and `int_vec`. On `int_ack`: clear PENDING[`int_vec`], set `int_req`=0, go to SERVICE. Clearing the MASK bit in REQ does not withdraw the request.
- SERVICE: wait for EOI, then go to IDLE. Nesting is not supported; new pending bits wait.

Ignored events and collisions:
- `int_ack` outside REQ is ignored. EOI outside SERVICE is ignored.
- `irq[i]` in the same cycle as a clear of bit i (by ack or W1C): the set wins, so no event is lost.
- `reg_re` and `reg_we` in the same cycle: `reg_rdata` returns the pre-write value.
- Reset mid-operation: all state returns to reset values. A request in flight is dropped without an ack.

Reset values: MASK=0, PENDING=0, RELOAD=0, state=IDLE, `int_req`=0, `int_vec`=0, `reg_rdata`=0, `tmr_nxt_int`=0, `tmr_nxt_int_we`=0.

## Timing
- `irq` sampled high at edge E sets PENDING after E. If the source is enabled and the FSM is in IDLE, `int_req` rises after E+1, so latency is 2 cycles.
- `int_ack` sampled at edge A drops `int_req` after A and enters SERVICE.
- EOI written at edge W returns to IDLE after W. The next `int_req` is visible no earlier than after W+1.
- `reg_rdata` updates on the edge where `reg_re`=1 and holds otherwise.
- `tmr_nxt_int_we` is a one-cycle registered pulse. `tmr_nxt_int` stays valid for the whole pulse cycle.

## Configuration
`INT_CTRL_TIMER_RELOAD_EN`:

Defined:
- When `irq[TIMER_SRC]` is sampled high at edge E and RELOAD≠0, `tmr_nxt_int`=RELOAD and `tmr_nxt_int_we`=1 for the cycle after E. This gives a periodic timer with period RELOAD·4096 clocks plus a fixed re-arm overhead.
- A RELOAD write with nonzero data also pulses `tmr_nxt_int_we` with that data in the next cycle, which arms the timer immediately.
- Writing 0 stops reloading and produces no pulse.
- If the source pulse and a RELOAD write occur in the same cycle, the written value is used.

Undefined:
- RELOAD reads 0 and writes to it are ignored.
- `tmr_nxt_int_we` and `tmr_nxt_int` are tied to 0.
- The timer is armed only by logic outside this block.

## Test plan
- Priority: MASK=0x00FF, pulse `irq[5]` and `irq[2]` in the same cycle -> `int_vec`=2 after 2 cycles. Ack, then EOI -> `int_vec`=5 one cycle after IDLE.
- Mask: MASK=0, pulse `irq[3]` -> PENDING=0x0008 and no `int_req`. Write MASK=0x0008 -> `int_req` with vector 3.
- Handshake: `int_ack` in IDLE -> no effect. Ack in REQ -> PENDING[vec]=0 and STATUS bit14=1. A second `irq` on the same source in SERVICE -> no request until EOI.
- Collision: W1C PENDING bit 4 in the same cycle `irq[4]` is high -> bit 4 remains 1.
- Reload (macro on): write RELOAD=3 -> next cycle `tmr_nxt_int`=3 and `tmr_nxt_int_we`=1. `irq[0]` pulse -> another single-cycle `we` pulse. RELOAD=0 followed by `irq[0]` -> no pulse. Macro off -> `we` never asserts.
- Reset: drive `rst_n` low for 1 cycle while in REQ -> after the edge, `int_req`=0 and all registers are 0.
